// File: rtl/mem_master.sv
// ---------------------------------------------------------------------------
// mem_master
//
// Burst initiator for a single-port synchronous memory. A burst request
// (start address + length) is accepted over a valid/ready handshake and is
// turned into a sequence of memory cycles at incrementing addresses.
//
//   * Write bursts take one beat per handshake on the wr_* stream and issue
//     one memory write per accepted beat (back-to-back beats give one write
//     per cycle).
//   * Read bursts issue one memory read per beat. Each beat is returned on
//     the rsp_* channel and held until the consumer takes it; the next beat
//     is not started until then.
//
// All mem_* pins are registered. Whenever the block is idle the memory is
// left disabled and in read mode.
//
// Ports
//   clk, rst_n        clock (posedge) and synchronous active-low reset
//   req_valid/ready   burst request handshake
//   req_wr            1 = write burst, 0 = read burst
//   req_addr          first address of the burst
//   req_len           beats minus one (0 = single beat)
//   wr_valid/ready    write beat handshake
//   wr_data           write beat payload
//   rsp_valid/ready   read beat handshake
//   rsp_data          read beat payload
//   rsp_last          marks the final beat of a read burst
//   busy              high whenever a burst is in progress
//   mem_enb           memory enable
//   mem_rd_wr         1 = read, 0 = write
//   mem_addr          memory address
//   mem_wdata         memory write data
//   mem_rdata         memory read data, valid the cycle after a read is
//                     sampled by the memory
// ---------------------------------------------------------------------------
module mem_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,

  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,

  output logic              busy,

  output logic              mem_enb,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] RD_ADDR = 3'd2;
  localparam logic [2:0] RD_DATA = 3'd3;
  localparam logic [2:0] RD_RSP  = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [LEN_W-1:0]  LEN_ONE  = 1;

  logic [2:0]        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  beat_cnt;

  // Set for the single IDLE cycle in which the last write of a burst is
  // still on the memory pins; no new request is taken in that cycle.
  logic              wr_drain;

  logic              req_hs;
  logic              wr_hs;
  logic              rsp_hs;
  logic              last_beat;
  logic [ADDR_W-1:0] next_addr;

  // Handshake qualifiers. The ready outputs are forced low while reset is
  // asserted so nothing is accepted on the edge that abandons a burst.
  assign req_ready = rst_n & (state == IDLE) & ~wr_drain;
  assign wr_ready  = rst_n & (state == WR);
  assign busy      = (state != IDLE);

  assign req_hs    = req_valid & req_ready;
  assign wr_hs     = wr_valid & wr_ready;
  assign rsp_hs    = rsp_valid & rsp_ready & (state == RD_RSP);

  assign last_beat = (beat_cnt == '0);

  // Address arithmetic wraps naturally at the top of the address space.
  assign next_addr = cur_addr + ADDR_ONE;

  // Burst sequencing: state, current address and remaining beat count.
  // The count only ever decrements when it is non-zero, so it cannot
  // underflow; reaching zero on an accepted beat ends the burst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_addr <= '0;
      beat_cnt <= '0;
      wr_drain <= 1'b0;
    end else begin
      wr_drain <= 1'b0;
      case (state)
        IDLE: begin
          if (req_hs) begin
            cur_addr <= req_addr;
            beat_cnt <= req_len;
            state    <= req_wr ? WR : RD_ADDR;
          end
        end
        WR: begin
          if (wr_hs) begin
            cur_addr <= next_addr;
            if (last_beat) begin
              state    <= IDLE;
              wr_drain <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt - LEN_ONE;
            end
          end
        end
        RD_ADDR: begin
          state <= RD_DATA;
        end
        RD_DATA: begin
          state <= RD_RSP;
        end
        RD_RSP: begin
          if (rsp_hs) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              beat_cnt <= beat_cnt - LEN_ONE;
              cur_addr <= next_addr;
              state    <= RD_ADDR;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory pin driver. Every cycle defaults to "disabled, read mode", so a
  // write is only ever presented for the one cycle after its beat was
  // accepted. A read is launched on the edge that enters RD_ADDR (so the
  // memory samples it at the end of RD_ADDR) and enable is held through
  // RD_DATA, when the memory drives its data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_enb   <= 1'b0;
      mem_rd_wr <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_enb   <= 1'b0;
      mem_rd_wr <= 1'b1;
      case (state)
        IDLE: begin
          if (req_hs && !req_wr) begin
            mem_enb  <= 1'b1;
            mem_addr <= req_addr;
          end
        end
        WR: begin
          if (wr_hs) begin
            mem_enb   <= 1'b1;
            mem_rd_wr <= 1'b0;
            mem_addr  <= cur_addr;
            mem_wdata <= wr_data;
          end
        end
        RD_ADDR: begin
          mem_enb <= 1'b1;
        end
        RD_RSP: begin
          if (rsp_hs && !last_beat) begin
            mem_enb  <= 1'b1;
            mem_addr <= next_addr;
          end
        end
        default: begin
          mem_enb <= 1'b0;
        end
      endcase
    end
  end

  // Read response register. Data is captured at the end of RD_DATA, while
  // the memory is still driving it, and then held untouched until the
  // consumer accepts the beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (state == RD_DATA) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mem_rdata;
        rsp_last  <= last_beat;
      end else if (rsp_hs) begin
        rsp_valid <= 1'b0;
        rsp_last  <= 1'b0;
      end
    end
  end

endmodule
